// File: rtl/dense_acc_array_pkg.sv
// Shared types and elaboration helpers for the dense-layer accumulator.
package dense_pkg;

  // Frame life cycle: wait for start, accumulate, round/saturate, hand out results.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    DRAIN = 2'd3
  } dense_state_e;

  // Smallest accumulator that holds N_IN full-width products plus the shifted bias.
  function automatic int min_acc_w(input int data_w, input int n_in);
    return 2 * data_w + $clog2(n_in) + 1;
  endfunction

  // Neuron index width; a single neuron still needs one bit of port.
  function automatic int idx_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

  // Saturation limits of a signed data_w-bit result.
  function automatic longint sat_hi(input int data_w);
    return (longint'(1) <<< (data_w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int data_w);
    return -(longint'(1) <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/dense_acc_array_if.sv
// Sample stream in, neuron results out, for the dense-layer accumulator.
interface dense_acc_array_if
  import dense_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_OUT  = 4
);
  localparam int IDX_W = idx_width(N_OUT);

  logic                       ena;
  logic                       frame_start_in;
  logic                       frame_end_in;
  logic signed [DATA_W-1:0]   dense_input;
  logic [N_OUT*DATA_W-1:0]    weight_in;
  logic [N_OUT*DATA_W-1:0]    bias_in;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   dense_sum_out;
  logic [IDX_W-1:0]           out_idx;
  logic                       valid;
  logic                       out_ready;
  logic                       len_err;

  // Accumulator side.
  modport slave (
    input  ena, frame_start_in, frame_end_in, dense_input, weight_in, bias_in, out_ready,
    output in_ready, dense_sum_out, out_idx, valid, len_err
  );

  // Producer / consumer side.
  modport master (
    output ena, frame_start_in, frame_end_in, dense_input, weight_in, bias_in, out_ready,
    input  in_ready, dense_sum_out, out_idx, valid, len_err
  );
endinterface

// File: rtl/dense_acc_array_round_sat.sv
// Round-half-up, scale back to data format, saturate and optionally rectify one neuron sum.
module dense_round_sat
  import dense_pkg::*;
#(
  parameter int ACC_W  = 40,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int RELU   = 1
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] res_o
);
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(longint'(1) <<< (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(DATA_W));

  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;

  // Round, shift out fraction bits, clamp to data range, then apply ReLU.
  always_comb begin
    biased  = acc_i + RND;
    shifted = biased >>> FRAC_W;
    if (shifted > SAT_HI) begin
      res_o = SAT_HI[DATA_W-1:0];
    end else if (shifted < SAT_LO) begin
      res_o = SAT_LO[DATA_W-1:0];
    end else begin
      res_o = shifted[DATA_W-1:0];
    end
    if ((RELU != 0) && res_o[DATA_W-1]) begin
      res_o = '0;
    end
  end
endmodule

// File: rtl/dense_acc_array.sv
// Dense-layer accumulator: N_OUT parallel neuron sums over a serial sample frame,
// drained one neuron per handshake.
module dense_acc_array
  import dense_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_IN   = 64,
  parameter int N_OUT  = 4,
  parameter int ACC_W  = 40,
  parameter int RELU   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dense_acc_array_if.slave bus
);
  localparam int IDX_W = idx_width(N_OUT);
  localparam int CNT_W = $clog2(N_IN + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_IN);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_IN + 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

  if (ACC_W < min_acc_w(DATA_W, N_IN)) begin : g_acc_w_check
    $error("dense_acc_array: ACC_W is too narrow for DATA_W and N_IN");
  end
  if (FRAC_W < 1) begin : g_frac_w_check
    $error("dense_acc_array: FRAC_W must be at least 1");
  end

  dense_state_e             state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q [N_OUT];
  logic signed [ACC_W-1:0]  acc_d [N_OUT];
  logic signed [DATA_W-1:0] res_q [N_OUT];
  logic signed [DATA_W-1:0] res_d [N_OUT];
  logic signed [DATA_W-1:0] rs_out [N_OUT];
  logic signed [ACC_W-1:0]  prod_ext [N_OUT];
  logic signed [ACC_W-1:0]  bias_ext [N_OUT];
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] x;
  logic                     accepting;
  logic                     accept;

  assign x = bus.dense_input;

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    logic signed [DATA_W-1:0]   w_j;
    logic signed [DATA_W-1:0]   b_j;
    logic signed [2*DATA_W-1:0] prod_j;

    assign w_j    = bus.weight_in[j*DATA_W +: DATA_W];
    assign b_j    = bus.bias_in[j*DATA_W +: DATA_W];
    assign prod_j = x * w_j;
    // Product sign-extended; bias moved into the product's fixed-point scale.
    assign prod_ext[j] = {{(ACC_W-2*DATA_W){prod_j[2*DATA_W-1]}}, prod_j};
    assign bias_ext[j] = {{(ACC_W-DATA_W-FRAC_W){b_j[DATA_W-1]}}, b_j, {FRAC_W{1'b0}}};

    dense_round_sat #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .RELU   (RELU)
    ) u_round_sat (
      .acc_i (acc_q[j]),
      .res_o (rs_out[j])
    );
  end

  // Samples are taken only while collecting a frame; held off during reset.
  always_comb begin
    accepting    = (state_q == IDLE) || (state_q == ACCUM);
    accept       = accepting && bus.ena;
    bus.in_ready = rst_n && accepting;
  end

  // Result port: only meaningful in DRAIN, zero otherwise.
  always_comb begin
    bus.valid         = (state_q == DRAIN);
    bus.out_idx       = idx_q;
    bus.dense_sum_out = (state_q == DRAIN) ? res_q[idx_q] : '0;
    bus.len_err       = (state_q == FINAL) && (cnt_q != CNT_FULL);
  end

  // Next-state, accumulation, result capture and drain indexing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    for (int j = 0; j < N_OUT; j++) begin
      acc_d[j] = acc_q[j];
      res_d[j] = res_q[j];
    end
    case (state_q)
      IDLE: begin
        if (accept && bus.frame_start_in) begin
          for (int j = 0; j < N_OUT; j++) acc_d[j] = bias_ext[j] + prod_ext[j];
          cnt_d   = CNT_ONE;
          state_d = bus.frame_end_in ? FINAL : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (bus.frame_start_in) begin
            for (int j = 0; j < N_OUT; j++) acc_d[j] = bias_ext[j] + prod_ext[j];
            cnt_d = CNT_ONE;
          end else begin
            for (int j = 0; j < N_OUT; j++) acc_d[j] = acc_q[j] + prod_ext[j];
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          end
          if (bus.frame_end_in) state_d = FINAL;
        end
      end
      FINAL: begin
        for (int j = 0; j < N_OUT; j++) res_d[j] = rs_out[j];
        idx_d   = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        acc_q[j] <= '0;
        res_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      for (int j = 0; j < N_OUT; j++) begin
        acc_q[j] <= acc_d[j];
        res_q[j] <= res_d[j];
      end
    end
  end
endmodule

// File: tb/tb_dense_acc_array.sv
// Directed bench for dense_acc_array: a RELU=0 and a RELU=1 instance share one stimulus.
module tb_dense_acc_array;
  logic clk;
  logic rst_n;
  logic ena, fs, fe, out_ready;
  logic signed [15:0] x;
  logic [31:0] w, b;

  int total = 0;
  int bad   = 0;

  // captured observations from one frame drain
  logic c_v_early, c_le0, c_le1, c_rdy_final, c_le_after;
  logic c_v0, c_v1, c_v_after, c_rdy_after;
  logic c_i0, c_i1;
  logic signed [15:0] c_d0, c_d1, c_r0, c_r1;

  dense_acc_array_if #(.DATA_W(16), .N_OUT(2)) bus0 ();
  dense_acc_array_if #(.DATA_W(16), .N_OUT(2)) bus1 ();

  assign bus0.ena = ena;            assign bus1.ena = ena;
  assign bus0.frame_start_in = fs;  assign bus1.frame_start_in = fs;
  assign bus0.frame_end_in = fe;    assign bus1.frame_end_in = fe;
  assign bus0.dense_input = x;      assign bus1.dense_input = x;
  assign bus0.weight_in = w;        assign bus1.weight_in = w;
  assign bus0.bias_in = b;          assign bus1.bias_in = b;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

  dense_acc_array #(.DATA_W(16), .FRAC_W(8), .N_IN(4), .N_OUT(2), .ACC_W(40), .RELU(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dense_acc_array #(.DATA_W(16), .FRAC_W(8), .N_IN(4), .N_OUT(2), .ACC_W(40), .RELU(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_samples(input int n, input logic signed [15:0] xv,
                              input logic signed [15:0] w0, input logic signed [15:0] w1,
                              input logic signed [15:0] b0, input logic signed [15:0] b1,
                              input bit with_start, input bit with_end);
    for (int i = 0; i < n; i++) begin
      ena = 1'b1;
      fs  = with_start && (i == 0);
      fe  = with_end && (i == n - 1);
      x   = xv;
      w   = {w1, w0};
      b   = {b1, b0};
      tick();
    end
    ena = 1'b0; fs = 1'b0; fe = 1'b0;
  endtask

  // Called #1 after the edge that took the end sample, out_ready held high.
  task automatic drain_capture();
    c_v_early = bus0.valid; c_le0 = bus0.len_err; c_le1 = bus1.len_err;
    c_rdy_final = bus0.in_ready;
    tick();
    c_v0 = bus0.valid; c_i0 = bus0.out_idx; c_d0 = bus0.dense_sum_out; c_r0 = bus1.dense_sum_out;
    c_le_after = bus0.len_err;
    tick();
    c_v1 = bus0.valid; c_i1 = bus0.out_idx; c_d1 = bus0.dense_sum_out; c_r1 = bus1.dense_sum_out;
    tick();
    c_v_after = bus0.valid; c_rdy_after = bus0.in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; fs = 1'b0; fe = 1'b0; x = '0; w = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus0.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", bus0.in_ready); end
    total++; if (bus0.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus0.valid); end
    total++; if (bus0.dense_sum_out !== 16'sd0) begin bad++; $display("FAIL reset_sum got=%0d exp=0", bus0.dense_sum_out); end
    total++; if (bus0.out_idx !== 1'b0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", bus0.out_idx); end
    total++; if (bus0.len_err !== 1'b0) begin bad++; $display("FAIL reset_len_err got=%0b exp=0", bus0.len_err); end
    rst_n = 1'b1;
    tick();
    total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%0b exp=1", bus0.in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_samples(4, 16'sd256, 16'sd256, -16'sd128, 16'sd0, 16'sd0, 1'b1, 1'b1);
    drain_capture();
    total++; if (c_v_early !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%0b exp=0", c_v_early); end
    total++; if (c_rdy_final !== 1'b0) begin bad++; $display("FAIL basic_ready_final got=%0b exp=0", c_rdy_final); end
    total++; if (c_le0 !== 1'b0) begin bad++; $display("FAIL basic_len_err got=%0b exp=0", c_le0); end
    total++; if (c_v0 !== 1'b1) begin bad++; $display("FAIL basic_valid0 got=%0b exp=1", c_v0); end
    total++; if (c_i0 !== 1'b0) begin bad++; $display("FAIL basic_idx0 got=%0d exp=0", c_i0); end
    total++; if (c_d0 !== 16'sd1024) begin bad++; $display("FAIL basic_d0 got=%0d exp=1024", c_d0); end
    total++; if (c_v1 !== 1'b1) begin bad++; $display("FAIL basic_valid1 got=%0b exp=1", c_v1); end
    total++; if (c_i1 !== 1'b1) begin bad++; $display("FAIL basic_idx1 got=%0d exp=1", c_i1); end
    total++; if (c_d1 !== -16'sd512) begin bad++; $display("FAIL basic_d1 got=%0d exp=-512", c_d1); end
    total++; if (c_v_after !== 1'b0) begin bad++; $display("FAIL basic_valid_after got=%0b exp=0", c_v_after); end
    total++; if (c_rdy_after !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%0b exp=1", c_rdy_after); end
  endtask

  task automatic test_relu();
    out_ready = 1'b1;
    send_samples(4, 16'sd256, 16'sd256, -16'sd128, 16'sd0, 16'sd0, 1'b1, 1'b1);
    drain_capture();
    total++; if (c_r0 !== 16'sd1024) begin bad++; $display("FAIL relu_r0 got=%0d exp=1024", c_r0); end
    total++; if (c_r1 !== 16'sd0) begin bad++; $display("FAIL relu_r1 got=%0d exp=0", c_r1); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    send_samples(4, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd0, 16'sd0, 1'b1, 1'b1);
    drain_capture();
    total++; if (c_d0 !== 16'sd32767) begin bad++; $display("FAIL sat_pos_d0 got=%0d exp=32767", c_d0); end
    total++; if (c_d1 !== 16'sd32767) begin bad++; $display("FAIL sat_pos_d1 got=%0d exp=32767", c_d1); end
    total++; if (c_r0 !== 16'sd32767) begin bad++; $display("FAIL sat_pos_r0 got=%0d exp=32767", c_r0); end
    send_samples(4, 16'sd32767, -16'sd32767, -16'sd32767, 16'sd0, 16'sd0, 1'b1, 1'b1);
    drain_capture();
    total++; if (c_d0 !== -16'sd32768) begin bad++; $display("FAIL sat_neg_d0 got=%0d exp=-32768", c_d0); end
    total++; if (c_d1 !== -16'sd32768) begin bad++; $display("FAIL sat_neg_d1 got=%0d exp=-32768", c_d1); end
    total++; if (c_r1 !== 16'sd0) begin bad++; $display("FAIL sat_neg_r1 got=%0d exp=0", c_r1); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_samples(4, 16'sd512, 16'sd256, 16'sd64, 16'sd0, 16'sd0, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      total++; if (bus0.valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%0b exp=1", k, bus0.valid); end
      total++; if (bus0.out_idx !== 1'b0) begin bad++; $display("FAIL bp_idx cyc=%0d got=%0d exp=0", k, bus0.out_idx); end
      total++; if (bus0.dense_sum_out !== 16'sd2048) begin bad++; $display("FAIL bp_sum cyc=%0d got=%0d exp=2048", k, bus0.dense_sum_out); end
      total++; if (bus0.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", k, bus0.in_ready); end
      ena = 1'b1; fs = 1'b1; fe = 1'b1; x = 16'sd1000; w = {16'sd300, 16'sd300}; b = {16'sd7, 16'sd7};
      tick();
    end
    ena = 1'b0; fs = 1'b0; fe = 1'b0;
    out_ready = 1'b1;
    total++; if (bus0.dense_sum_out !== 16'sd2048) begin bad++; $display("FAIL bp_release_d0 got=%0d exp=2048", bus0.dense_sum_out); end
    tick();
    total++; if (bus0.out_idx !== 1'b1) begin bad++; $display("FAIL bp_release_idx1 got=%0d exp=1", bus0.out_idx); end
    total++; if (bus0.dense_sum_out !== 16'sd512) begin bad++; $display("FAIL bp_release_d1 got=%0d exp=512", bus0.dense_sum_out); end
    tick();
    total++; if (bus0.valid !== 1'b0) begin bad++; $display("FAIL bp_done_valid got=%0b exp=0", bus0.valid); end
    send_samples(4, 16'sd256, 16'sd256, -16'sd128, 16'sd0, 16'sd0, 1'b1, 1'b1);
    drain_capture();
    total++; if (c_d0 !== 16'sd1024) begin bad++; $display("FAIL bp_next_d0 got=%0d exp=1024", c_d0); end
    total++; if (c_d1 !== -16'sd512) begin bad++; $display("FAIL bp_next_d1 got=%0d exp=-512", c_d1); end
  endtask

  task automatic test_len_err();
    out_ready = 1'b1;
    send_samples(3, 16'sd256, 16'sd256, -16'sd128, 16'sd1, -16'sd2, 1'b1, 1'b1);
    drain_capture();
    total++; if (c_le0 !== 1'b1) begin bad++; $display("FAIL len3_err got=%0b exp=1", c_le0); end
    total++; if (c_le1 !== 1'b1) begin bad++; $display("FAIL len3_err_relu got=%0b exp=1", c_le1); end
    total++; if (c_le_after !== 1'b0) begin bad++; $display("FAIL len3_err_pulse got=%0b exp=0", c_le_after); end
    total++; if (c_d0 !== 16'sd769) begin bad++; $display("FAIL len3_d0 got=%0d exp=769", c_d0); end
    total++; if (c_d1 !== -16'sd386) begin bad++; $display("FAIL len3_d1 got=%0d exp=-386", c_d1); end
    send_samples(1, 16'sd256, 16'sd256, 16'sd256, 16'sd2, -16'sd3, 1'b1, 1'b1);
    drain_capture();
    total++; if (c_le0 !== 1'b1) begin bad++; $display("FAIL single_err got=%0b exp=1", c_le0); end
    total++; if (c_d0 !== 16'sd258) begin bad++; $display("FAIL single_d0 got=%0d exp=258", c_d0); end
    total++; if (c_d1 !== 16'sd253) begin bad++; $display("FAIL single_d1 got=%0d exp=253", c_d1); end
  endtask

  task automatic test_restart();
    out_ready = 1'b1;
    send_samples(2, 16'sd1000, 16'sd256, 16'sd256, 16'sd5, 16'sd5, 1'b1, 1'b0);
    send_samples(4, 16'sd256, 16'sd256, -16'sd128, 16'sd0, 16'sd0, 1'b1, 1'b1);
    drain_capture();
    total++; if (c_le0 !== 1'b0) begin bad++; $display("FAIL restart_len_err got=%0b exp=0", c_le0); end
    total++; if (c_d0 !== 16'sd1024) begin bad++; $display("FAIL restart_d0 got=%0d exp=1024", c_d0); end
    total++; if (c_d1 !== -16'sd512) begin bad++; $display("FAIL restart_d1 got=%0d exp=-512", c_d1); end
  endtask

  task automatic test_reset_drain();
    out_ready = 1'b1;
    send_samples(4, 16'sd512, 16'sd256, 16'sd64, 16'sd0, 16'sd0, 1'b1, 1'b1);
    tick();
    tick();
    out_ready = 1'b0;
    total++; if (bus0.out_idx !== 1'b1) begin bad++; $display("FAIL rstd_pre_idx got=%0d exp=1", bus0.out_idx); end
    rst_n = 1'b0;
    #1;
    total++; if (bus0.valid !== 1'b0) begin bad++; $display("FAIL rstd_valid got=%0b exp=0", bus0.valid); end
    total++; if (bus0.dense_sum_out !== 16'sd0) begin bad++; $display("FAIL rstd_sum got=%0d exp=0", bus0.dense_sum_out); end
    total++; if (bus0.in_ready !== 1'b0) begin bad++; $display("FAIL rstd_in_ready got=%0b exp=0", bus0.in_ready); end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL rstd_ready_after got=%0b exp=1", bus0.in_ready); end
    tick();
    total++; if (bus0.valid !== 1'b0) begin bad++; $display("FAIL rstd_no_partial got=%0b exp=0", bus0.valid); end
    send_samples(4, 16'sd256, 16'sd256, -16'sd128, 16'sd0, 16'sd0, 1'b1, 1'b1);
    drain_capture();
    total++; if (c_d0 !== 16'sd1024) begin bad++; $display("FAIL rstd_next_d0 got=%0d exp=1024", c_d0); end
    total++; if (c_d1 !== -16'sd512) begin bad++; $display("FAIL rstd_next_d1 got=%0d exp=-512", c_d1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_backpressure();
    test_len_err();
    test_restart();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
